// File: rtl/proc_check_monitor_if.sv
// ---------------------------------------------------------------------------
// proc_check_monitor_if
//   Observation/control bus between the single-cycle processor and its
//   self-check monitor.
//   Signals:
//     currentpc    processor PC                       (processor -> monitor)
//     MemtoRegOut  processor writeback value          (processor -> monitor)
//     proc_resetl  active-low processor reset         (monitor -> processor)
//   Modports:
//     master  processor side
//     slave   monitor side
// ---------------------------------------------------------------------------
interface proc_check_monitor_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] currentpc;
    logic [DATA_W-1:0] MemtoRegOut;
    logic              proc_resetl;

    modport master (output currentpc, output MemtoRegOut, input proc_resetl);
    modport slave  (input currentpc, input MemtoRegOut, output proc_resetl);
endinterface

// File: rtl/proc_check_monitor.sv
// ---------------------------------------------------------------------------
// proc_check_monitor
//   Self-check harness for the single-cycle processor. It holds the processor
//   in reset for RST_CYC cycles after start and then releases it. Every time
//   the PC reaches the next checkpoint, it compares the writeback value with
//   the expected value. A per-checkpoint watchdog ends runs that stall.
//   Ports:
//     CLK, Reset      clock, synchronous active-high reset
//     start           run request pulse (honoured in IDLE/DONE only)
//     chk_count       number of active checkpoints, latched on start
//     chk_pc/chk_val  packed checkpoint PCs / expected values
//     wdog_limit      cycle budget per checkpoint (0 = off), latched on start
//     bus             processor observation bus (slave side)
//     busy/done       run status
//     all_passed      qualified pass flag, valid in DONE
//     timeout         watchdog expired during the run
//     pass_count      checkpoints passed so far
//     check_idx       checkpoint currently awaited
//     fail_mask       per-checkpoint failed / not-reached flags
//     fail_value      writeback value at the first failing compare
// ---------------------------------------------------------------------------
module proc_check_monitor #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int NUM_CHECKS = 4,
    parameter int IDX_W      = $clog2(NUM_CHECKS + 1),
    parameter int WDOG_W     = 16,
    parameter int RST_CYC    = 2
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [IDX_W-1:0]             chk_count,
    input  logic [NUM_CHECKS*ADDR_W-1:0] chk_pc,
    input  logic [NUM_CHECKS*DATA_W-1:0] chk_val,
    input  logic [WDOG_W-1:0]            wdog_limit,
    proc_check_monitor_if.slave          bus,
    output logic                         busy,
    output logic                         done,
    output logic                         all_passed,
    output logic                         timeout,
    output logic [IDX_W-1:0]             pass_count,
    output logic [IDX_W-1:0]             check_idx,
    output logic [NUM_CHECKS-1:0]        fail_mask,
    output logic [DATA_W-1:0]            fail_value
);
    // Tables are padded to a power of two so check_idx indexes them at its
    // natural width; padded slots are never reached while running.
    localparam int SLOTS  = 1 << IDX_W;
    localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      chk_count_q;
    logic [WDOG_W-1:0]     wdog_limit_q;
    logic [WDOG_W-1:0]     wdog_q;
    logic [HOLD_W-1:0]     hold_q;
    logic                  timeout_q;
    logic [IDX_W-1:0]      pass_count_q;
    logic [IDX_W-1:0]      check_idx_q;
    logic [NUM_CHECKS-1:0] fail_mask_q;
    logic [DATA_W-1:0]     fail_value_q;

    logic [ADDR_W-1:0] pc_tab  [SLOTS];
    logic [DATA_W-1:0] val_tab [SLOTS];

    for (genvar g = 0; g < SLOTS; g++) begin : g_tab
        if (g < NUM_CHECKS) begin : g_live
            assign pc_tab[g]  = chk_pc[g*ADDR_W +: ADDR_W];
            assign val_tab[g] = chk_val[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign pc_tab[g]  = '0;
            assign val_tab[g] = '0;
        end
    end

    logic              retire;
    logic              hit;
    logic              last;
    logic              expire;
    logic [WDOG_W-1:0] wdog_inc;
    logic [NUM_CHECKS-1:0] cur_bit;
    logic [NUM_CHECKS-1:0] tail_mask;

    assign retire   = (state_q == S_RUN) && (bus.currentpc >= pc_tab[check_idx_q]);
    assign hit      = (bus.MemtoRegOut == val_tab[check_idx_q]);
    assign last     = ((check_idx_q + IDX_W'(1)) == chk_count_q);
    assign wdog_inc = wdog_q + WDOG_W'(1);
    // The watchdog budget counts non-retiring RUN cycles: expiry happens on
    // the cycle that would bring the count up to the limit.
    assign expire   = (wdog_limit_q != '0) && (wdog_inc == wdog_limit_q);

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        cur_bit   = '0;
        tail_mask = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            cur_bit[i]   = (IDX_W'(i) == check_idx_q);
            tail_mask[i] = (IDX_W'(i) >= check_idx_q) && (IDX_W'(i) < chk_count_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            chk_count_q  <= '0;
            wdog_limit_q <= '0;
            wdog_q       <= '0;
            hold_q       <= '0;
            timeout_q    <= 1'b0;
            pass_count_q <= '0;
            check_idx_q  <= '0;
            fail_mask_q  <= '0;
            fail_value_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_HOLD;
                        chk_count_q  <= chk_count;
                        wdog_limit_q <= wdog_limit;
                        wdog_q       <= '0;
                        hold_q       <= '0;
                        timeout_q    <= 1'b0;
                        pass_count_q <= '0;
                        check_idx_q  <= '0;
                        fail_mask_q  <= '0;
                        fail_value_q <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_W'(RST_CYC - 1)) begin
                        state_q <= (chk_count_q == '0) ? S_DONE : S_RUN;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    // A retire takes priority over a simultaneous expiry.
                    if (retire) begin
                        if (hit) begin
                            pass_count_q <= pass_count_q + IDX_W'(1);
                        end else begin
                            fail_mask_q <= fail_mask_q | cur_bit;
                            // No compare has failed yet while the mask is
                            // clear (timeouts only set bits on exit).
                            if (fail_mask_q == '0) fail_value_q <= bus.MemtoRegOut;
                        end
                        check_idx_q <= check_idx_q + IDX_W'(1);
                        wdog_q      <= '0;
                        if (last) state_q <= S_DONE;
                    end else if (expire) begin
                        timeout_q   <= 1'b1;
                        fail_mask_q <= fail_mask_q | tail_mask;
                        state_q     <= S_DONE;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status outputs decode registered state directly, so they are glitch-free.
    assign bus.proc_resetl = (state_q == S_RUN);
    assign busy            = (state_q == S_HOLD) || (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign all_passed      = done && (pass_count_q == chk_count_q) && !timeout_q;
    assign timeout         = timeout_q;
    assign pass_count      = pass_count_q;
    assign check_idx       = check_idx_q;
    assign fail_mask       = fail_mask_q;
    assign fail_value      = fail_value_q;
endmodule

// File: tb/tb_proc_check_monitor.sv
// ---------------------------------------------------------------------------
// tb_proc_check_monitor
//   Directed bench for proc_check_monitor with default parameters
//   (64-bit data/PC, 4 checkpoints, 16-bit watchdog, RST_CYC=2). A simple
//   processor stand-in steps the PC by 4 per cycle once released from reset.
// ---------------------------------------------------------------------------
module tb_proc_check_monitor;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int NUM_CHECKS = 4;
    localparam int IDX_W = 3;
    localparam int WDOG_W = 16;
    localparam logic [63:0] BIG = 64'h1234_5678_9abc_def0;

    logic                         CLK = 1'b0;
    logic                         Reset;
    logic                         start;
    logic [IDX_W-1:0]             chk_count;
    logic [NUM_CHECKS*ADDR_W-1:0] chk_pc;
    logic [NUM_CHECKS*DATA_W-1:0] chk_val;
    logic [WDOG_W-1:0]            wdog_limit;
    logic                         busy, done, all_passed, timeout;
    logic [IDX_W-1:0]             pass_count, check_idx;
    logic [NUM_CHECKS-1:0]        fail_mask;
    logic [DATA_W-1:0]            fail_value;

    int errors = 0;
    int checks = 0;

    proc_check_monitor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) pbus ();

    proc_check_monitor dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .chk_count  (chk_count),
        .chk_pc     (chk_pc),
        .chk_val    (chk_val),
        .wdog_limit (wdog_limit),
        .bus        (pbus),
        .busy       (busy),
        .done       (done),
        .all_passed (all_passed),
        .timeout    (timeout),
        .pass_count (pass_count),
        .check_idx  (check_idx),
        .fail_mask  (fail_mask),
        .fail_value (fail_value)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_table(input logic [63:0] pc0, input logic [63:0] pc1,
                             input logic [63:0] v0, input logic [63:0] v1);
        chk_pc  = '0;
        chk_val = '0;
        chk_pc[0 +: 64]  = pc0;
        chk_pc[64 +: 64] = pc1;
        chk_val[0 +: 64]  = v0;
        chk_val[64 +: 64] = v1;
    endtask

    // Pulses start, then covers the two HOLD cycles.
    task automatic start_run(input logic [IDX_W-1:0] cnt, input logic [WDOG_W-1:0] lim);
        chk_count  = cnt;
        wdog_limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_count  = '0;   // must have been latched on start
        wdog_limit = '0;
        checks++;
        if ({busy, done, pbus.proc_resetl} !== 3'b100) begin
            errors++;
            $display("FAIL hold_entry: busy/done/resetl=%b required 100", {busy, done, pbus.proc_resetl});
        end
        tick();
        checks++;
        if ({busy, done, pbus.proc_resetl} !== 3'b100) begin
            errors++;
            $display("FAIL hold_second: busy/done/resetl=%b required 100", {busy, done, pbus.proc_resetl});
        end
    endtask

    task automatic expect_release();
        tick();
        checks++;
        if (pbus.proc_resetl !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL release: resetl=%b busy=%b required 1 1", pbus.proc_resetl, busy);
        end
    endtask

    // Processor stand-in: PC from 0 in steps of 4; writeback v30 at 0x30 and
    // BIG at 0x5c, zero elsewhere.
    task automatic run_model(input logic [63:0] v30, input logic [IDX_W-1:0] pass_at_30,
                             input bit stop_early);
        logic [63:0] pc;
        pc = 64'h0;
        for (int i = 0; i < 64; i++) begin
            pbus.currentpc   = pc;
            pbus.MemtoRegOut = (pc == 64'h30) ? v30 : (pc == 64'h5c) ? BIG : 64'h0;
            tick();
            if (pc == 64'h30) begin
                checks++;
                if (pass_count !== pass_at_30 || check_idx !== 3'd1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL first_retire: pass=%0d idx=%0d done=%b required %0d 1 0",
                             pass_count, check_idx, done, pass_at_30);
                end
                if (stop_early) return;
            end
            if (done) break;
            pc += 64'h4;
        end
        checks++;
        if (done !== 1'b1 || pc !== 64'h5c) begin
            errors++;
            $display("FAIL run_end: done=%b at pc=%h required done=1 at pc=5c", done, pc);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        start = 1'b0;
        chk_count = '0;
        wdog_limit = '0;
        chk_pc = '0;
        chk_val = '0;
        pbus.currentpc = '0;
        pbus.MemtoRegOut = '0;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if ({pbus.proc_resetl, busy, done, all_passed, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: resetl/busy/done/allp/tmo=%b required 00000",
                     {pbus.proc_resetl, busy, done, all_passed, timeout});
        end
        checks++;
        if (pass_count !== 3'd0 || check_idx !== 3'd0 || fail_mask !== 4'd0 || fail_value !== 64'd0) begin
            errors++;
            $display("FAIL reset_counts: pass=%0d idx=%0d mask=%b fval=%h required all zero",
                     pass_count, check_idx, fail_mask, fail_value);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays: busy=%b required 0", busy);
        end
    endtask

    task automatic test_pass();
        set_table(64'h30, 64'h5c, 64'hF, BIG);
        pbus.currentpc = '0;
        start_run(3'd2, 16'd100);
        expect_release();
        run_model(64'hF, 3'd1, 1'b0);
        checks++;
        if (pass_count !== 3'd2 || all_passed !== 1'b1 || fail_mask !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL pass_result: pass=%0d allp=%b mask=%b tmo=%b required 2 1 0000 0",
                     pass_count, all_passed, fail_mask, timeout);
        end
        tick();
        tick();
        checks++;
        if ({done, busy, pbus.proc_resetl} !== 3'b100 || pass_count !== 3'd2 || check_idx !== 3'd2) begin
            errors++;
            $display("FAIL done_hold: done/busy/resetl=%b pass=%0d idx=%0d required 100 2 2",
                     {done, busy, pbus.proc_resetl}, pass_count, check_idx);
        end
    endtask

    task automatic test_fail();
        set_table(64'h30, 64'h5c, 64'hF, BIG);
        pbus.currentpc = '0;
        start_run(3'd2, 16'd100);
        expect_release();
        run_model(64'hE, 3'd0, 1'b0);
        checks++;
        if (fail_mask !== 4'b0001 || fail_value !== 64'hE || pass_count !== 3'd1 || all_passed !== 1'b0) begin
            errors++;
            $display("FAIL fail_result: mask=%b fval=%h pass=%0d allp=%b required 0001 e 1 0",
                     fail_mask, fail_value, pass_count, all_passed);
        end
    endtask

    task automatic test_timeout();
        set_table(64'h30, 64'h5c, 64'hF, BIG);
        pbus.currentpc = 64'h10;
        pbus.MemtoRegOut = '0;
        start_run(3'd2, 16'hFF);
        expect_release();
        repeat (254) tick();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: tmo=%b done=%b after 254 cycles required 0 0", timeout, done);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1 || fail_mask !== 4'b0011 || all_passed !== 1'b0
            || pass_count !== 3'd0 || pbus.proc_resetl !== 1'b0) begin
            errors++;
            $display("FAIL wdog_expire: tmo=%b done=%b mask=%b allp=%b pass=%0d resetl=%b required 1 1 0011 0 0 0",
                     timeout, done, fail_mask, all_passed, pass_count, pbus.proc_resetl);
        end
    endtask

    task automatic test_zero_checks();
        pbus.currentpc = '0;
        start_run(3'd0, 16'd0);
        tick();
        checks++;
        if (done !== 1'b1 || all_passed !== 1'b1 || pbus.proc_resetl !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_checks: done=%b allp=%b resetl=%b busy=%b required 1 1 0 0",
                     done, all_passed, pbus.proc_resetl, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        set_table(64'h30, 64'h5c, 64'hF, BIG);
        pbus.currentpc = '0;
        start_run(3'd2, 16'd0);
        expect_release();
        run_model(64'hF, 3'd1, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({pbus.proc_resetl, busy, done, all_passed, timeout} !== 5'b0
            || pass_count !== 3'd0 || check_idx !== 3'd0 || fail_mask !== 4'd0 || fail_value !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b pass=%0d idx=%0d mask=%b fval=%h required all zero",
                     {pbus.proc_resetl, busy, done, all_passed, timeout}, pass_count, check_idx,
                     fail_mask, fail_value);
        end
        test_pass();
    endtask

    task automatic test_back_to_back();
        set_table(64'h20, 64'h20, 64'hA, 64'hB);
        pbus.currentpc = '0;
        pbus.MemtoRegOut = '0;
        start_run(3'd2, 16'd0);
        expect_release();
        for (int i = 0; i < 8; i++) begin
            pbus.currentpc = 64'(i * 4);
            start = (i == 3);   // must be ignored while running
            tick();
            start = 1'b0;
        end
        checks++;
        if (pass_count !== 3'd0 || check_idx !== 3'd0 || pbus.proc_resetl !== 1'b1) begin
            errors++;
            $display("FAIL pre_checkpoint: pass=%0d idx=%0d resetl=%b required 0 0 1",
                     pass_count, check_idx, pbus.proc_resetl);
        end
        pbus.currentpc   = 64'h20;
        pbus.MemtoRegOut = 64'hA;
        tick();
        checks++;
        if (pass_count !== 3'd1 || check_idx !== 3'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL same_pc_first: pass=%0d idx=%0d done=%b required 1 1 0", pass_count, check_idx, done);
        end
        pbus.MemtoRegOut = 64'hB;
        tick();
        checks++;
        if (pass_count !== 3'd2 || done !== 1'b1 || all_passed !== 1'b1 || fail_mask !== 4'b0000) begin
            errors++;
            $display("FAIL same_pc_second: pass=%0d done=%b allp=%b mask=%b required 2 1 1 0000",
                     pass_count, done, all_passed, fail_mask);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_zero_checks();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proc_check_monitor.md
# proc_check_monitor

Synthesizable self-check harness for the single-cycle processor: it sequences processor reset, watches `currentpc` against a programmable list of checkpoint PCs, and compares `MemtoRegOut` against the expected value at each checkpoint. It also runs a restartable watchdog and reports pass/fail per checkpoint. It sits beside `singlecycle`, driving its reset and observing its outputs, and is parametrised in data width, PC width, checkpoint count and watchdog width.

## Interface
- `DATA_W`, 64, width of `MemtoRegOut` and expected values
- `ADDR_W`, 64, PC width
- `NUM_CHECKS`, 4, maximum checkpoints (≥1)
- `IDX_W`, `$clog2(NUM_CHECKS+1)`, width of counts and indices
- `WDOG_W`, 16, watchdog counter width
- `RST_CYC`, 2, cycles the processor reset is held after `start`
- `CLK`  in  1  clock; all logic on rising edge
- `Reset`  in  1  reset; synchronous, active-high
- `start`  in  1  one-cycle pulse that begins a run; ignored unless in IDLE or DONE
- `chk_count`  in  IDX_W  number of active checkpoints (0..NUM_CHECKS); sampled on `start`
- `chk_pc`  in  NUM_CHECKS*ADDR_W  checkpoint PCs, entry i at bits [i*ADDR_W +: ADDR_W]; must be non-decreasing
- `chk_val`  in  NUM_CHECKS*DATA_W  expected values, same packing
- `wdog_limit`  in  WDOG_W  cycle budget per checkpoint; sampled on `start`
- `currentpc`  in  ADDR_W  processor PC
- `MemtoRegOut`  in  DATA_W  processor writeback value
- `proc_resetl`  out  1  active-low processor reset
- `busy`  out  1  high in HOLD and RUN
- `done`  out  1  high in DONE
- `all_passed`  out  1  valid in DONE: `pass_count == chk_count` and no timeout
- `timeout`  out  1  watchdog expired during the run
- `pass_count`  out  IDX_W  checkpoints passed so far
- `check_idx`  out  IDX_W  index of the checkpoint currently awaited
- `fail_mask`  out  NUM_CHECKS  bit i set when checkpoint i failed or was never reached
- `fail_value`  out  DATA_W  `MemtoRegOut` captured at the first failing compare

## Operation
- States: IDLE, HOLD, RUN, DONE.
- IDLE → HOLD on `start`:
  - latch `chk_count` and `wdog_limit`
  - clear `pass_count`, `fail_mask`, `timeout`, `fail_value`, `check_idx`, watchdog, hold counter
- HOLD: `proc_resetl`=0 for exactly RST_CYC cycles, then → RUN. If `chk_count`==0, HOLD → DONE instead, with `all_passed`=1.
- RUN: `proc_resetl`=1. On each edge with `currentpc >= chk_pc[check_idx]` (unsigned):
  - if `MemtoRegOut == chk_val[check_idx]`, increment `pass_count`
  - otherwise set `fail_mask[check_idx]`; capture `fail_value` only if it is the first failure
  - increment `check_idx` and clear the watchdog
  - after the last active check, → DONE
- At most one checkpoint is retired per cycle. Equal consecutive PCs retire on successive cycles, each comparing the `MemtoRegOut` present in that cycle.
- Watchdog:
  - increments each RUN cycle without a retire
  - if it equals `wdog_limit` before a retire, set `timeout`, set `fail_mask` bits `check_idx`..`chk_count-1`, and → DONE
  - a retire and expiry in the same cycle: the retire wins and the watchdog clears
  - `wdog_limit`==0 disables the watchdog
- DONE: `proc_resetl`=0 (processor frozen in reset), all results held. `start` → HOLD (new run).
- `start` in HOLD/RUN is ignored.

## Timing
- Reset values: state IDLE, `proc_resetl`=0, `busy`=0, `done`=0, `all_passed`=0, `timeout`=0, `pass_count`=0, `check_idx`=0, `fail_mask`=0, `fail_value`=0.
- `Reset` mid-run returns everything to reset values on the next edge, and `proc_resetl` drops that edge.
- `start` at edge t: `busy`=1 and `proc_resetl`=0 from t+1; `proc_resetl`=1 from t+1+RST_CYC.
- A compare evaluated at edge t is visible on `pass_count`/`fail_mask`/`check_idx` after t.
- The final retire at edge t makes `done`=1 after t.
- `all_passed` is combinational from registered state and is qualified by `done`.

## Test plan
- Two checks, `chk_pc`={0x30,0x5c}, `chk_val`={0xF,0x123456789abcdef0}, processor model matches both → `done`=1, `pass_count`=2, `all_passed`=1, `fail_mask`=0.
- Same setup, but the model outputs 0xE at 0x30 → `fail_mask`=0b01, `fail_value`=0xE, `pass_count`=1, `all_passed`=0.
- `wdog_limit`=0xFF, PC stuck at 0x10 → `timeout`=1 exactly 255 RUN cycles after `proc_resetl` rises, `fail_mask`=0b11, `done`=1.
- `chk_count`=0 → `done`=1 after RST_CYC cycles, `all_passed`=1, `proc_resetl` never rises.
- Assert `Reset` during RUN after one pass → next cycle all outputs at reset values. Then `start` performs a clean full run.
- Two checks at the same PC 0x20 with expected values 0xA and 0xB; the model presents 0xA, then 0xB on the next cycle → both pass on consecutive edges, `pass_count` goes 1 then 2.
